// File: rtl/rob_rename_sequencer_pkg.sv
// Shared sizing and entry layout for the reorder-buffer rename sequencer.
package rob_rename_sequencer_pkg;

    localparam int DEPTH = 32;
    localparam int TAG_W = 5;
    localparam int REG_W = 5;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [REG_W-1:0] dest;
    } rob_entry_t;

endpackage

// File: rtl/rob_ring_ptr.sv
// Wrapping ring pointer: advances by 0, 1 or 2 each cycle, synchronous clear has priority.
module rob_ring_ptr #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [1:0]       inc,
    output logic [TAG_W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + TAG_W'(inc);
        end
    end

endmodule

// File: rtl/rob_rename_sequencer.sv
// Allocates ROB tags in order, drives the alias-table write port, and retires up to two done entries per cycle.
module rob_rename_sequencer
    import rob_rename_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_req,
    input  logic [REG_W-1:0] alloc_dest,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             rat_write,
    output logic [REG_W-1:0] rat_dest,
    output logic [TAG_W-1:0] rat_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    output logic             free0,
    output logic             free1,
    output logic [REG_W-1:0] free0_dest,
    output logic [REG_W-1:0] free1_dest,
    output logic [TAG_W-1:0] free0_tag,
    output logic [TAG_W-1:0] free1_tag,
    output logic [TAG_W:0]   count,
    output logic             empty,
    output logic             full
);

    rob_entry_t       entries [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W-1:0] head_p1;
    logic             grant;
    logic             r0;
    logic             r1;
    logic [1:0]       head_inc;
    logic [1:0]       tail_inc;

    assign empty       = (count == '0);
    assign full        = (count == (TAG_W+1)'(DEPTH));
    // Room is judged on registered count only; a same-cycle retire does not free a slot.
    assign alloc_ready = ~full & ~flush;
    assign grant       = alloc_req & alloc_ready;
    assign alloc_tag   = tail;
    assign rat_write   = grant;
    assign rat_dest    = alloc_dest;
    assign rat_tag     = tail;

    assign head_p1  = head + TAG_W'(1);
    assign r0       = entries[head].valid & entries[head].done;
    assign r1       = r0 & entries[head_p1].valid & entries[head_p1].done;
    assign head_inc = {1'b0, r0} + {1'b0, r1};
    assign tail_inc = {1'b0, grant};

    rob_ring_ptr #(.TAG_W(TAG_W)) u_head (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (head_inc),
        .ptr   (head)
    );

    rob_ring_ptr #(.TAG_W(TAG_W)) u_tail (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (tail_inc),
        .ptr   (tail)
    );

    // Writeback is applied before retire and grant so a retired or fresh slot always ends clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            if (wb_valid && entries[wb_tag].valid) entries[wb_tag].done <= 1'b1;
            if (r0) entries[head] <= '0;
            if (r1) entries[head_p1] <= '0;
            if (grant) begin
                entries[tail].valid <= 1'b1;
                entries[tail].done  <= 1'b0;
                entries[tail].dest  <= alloc_dest;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + (TAG_W+1)'(grant) - (TAG_W+1)'(r0) - (TAG_W+1)'(r1);
        end
    end

    // Free ports pulse for one cycle; dest/tag hold their last retired values otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free0      <= 1'b0;
            free1      <= 1'b0;
            free0_dest <= '0;
            free1_dest <= '0;
            free0_tag  <= '0;
            free1_tag  <= '0;
        end else if (flush) begin
            free0 <= 1'b0;
            free1 <= 1'b0;
        end else begin
            free0 <= r0;
            free1 <= r1;
            if (r0) begin
                free0_dest <= entries[head].dest;
                free0_tag  <= head;
            end
            if (r1) begin
                free1_dest <= entries[head_p1].dest;
                free1_tag  <= head_p1;
            end
        end
    end

endmodule
